// File: rtl/sr_reg_file_pkg.sv
// Shared op encodings and sequencer state type for the set/clear register file.
package sr_reg_pkg;

    typedef enum logic [1:0] {
        OP_HOLD  = 2'b00,
        OP_WRITE = 2'b01,
        OP_SET   = 2'b10,
        OP_CLR   = 2'b11
    } op_e;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_CLEARING = 1'b1
    } state_e;

endpackage

// File: rtl/sr_reg_file_word.sv
// One storage word with write/set/clear next-state logic and a sequencer clear.
// SR_REG_FILE_BYPASS_EN selects whether rd shows the post-update (write-first) value.
module sr_word
    import sr_reg_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] mask,
    input  logic             seq_clr,
    output logic [WIDTH-1:0] rd
);

    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_next;

    // The sequencer clear wins; the top never enables an op while clearing anyway.
    always_comb begin
        q_next = q;
        if (seq_clr) begin
            q_next = '0;
        end else if (en) begin
            case (op_e'(op))
                OP_WRITE: q_next = mask;
                OP_SET:   q_next = q | mask;
                OP_CLR:   q_next = q & ~mask;
                default:  q_next = q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) q <= '0;
        else     q <= q_next;
    end

`ifdef SR_REG_FILE_BYPASS_EN
    assign rd = q_next;
`else
    assign rd = q;
`endif

endmodule

// File: rtl/sr_reg_file.sv
// Register file of set/clear words with two registered read ports and a clear-all sequencer.
// Read-during-update behaviour follows SR_REG_FILE_BYPASS_EN (see sr_word).
module sr_reg_file
    import sr_reg_pkg::*;
#(
    parameter  int WIDTH  = 8,
    parameter  int DEPTH  = 16,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        op,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    output logic [WIDTH-1:0]  rdata_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [WIDTH-1:0]  rdata_b,
    input  logic              clr_all_req,
    output logic              busy
);

    state_e            state;
    state_e            state_nxt;
    logic [ADDR_W-1:0] ptr;
    logic              accept;
    logic [WIDTH-1:0]  word_rd [DEPTH];
    logic [WIDTH-1:0]  rd_a;
    logic [WIDTH-1:0]  rd_b;

    assign accept = (state == ST_IDLE);

    // Out-of-range waddr matches no word, so the op falls away naturally.
    for (genvar i = 0; i < DEPTH; i++) begin : g_word
        sr_word #(.WIDTH(WIDTH)) u_word (
            .clk     (clk),
            .rst     (rst),
            .en      (accept && (waddr == ADDR_W'(i))),
            .op      (op),
            .mask    (wdata),
            .seq_clr ((state == ST_CLEARING) && (ptr == ADDR_W'(i))),
            .rd      (word_rd[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE) ptr <= '0;
            else                  ptr <= ptr + ADDR_W'(1);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:     if (clr_all_req) state_nxt = ST_CLEARING;
            ST_CLEARING: if (ptr == ADDR_W'(DEPTH - 1)) state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state == ST_CLEARING);
    end

    // Address compare per word keeps out-of-range reads at zero.
    always_comb begin
        rd_a = '0;
        rd_b = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (raddr_a == ADDR_W'(i)) rd_a = word_rd[i];
            if (raddr_b == ADDR_W'(i)) rd_b = word_rd[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_a <= '0;
            rdata_b <= '0;
        end else begin
            rdata_a <= rd_a;
            rdata_b <= rd_b;
        end
    end

endmodule

// File: tb/tb_sr_reg_file.sv
// Bench for sr_reg_file: directed plan plus randomized traffic against an array model.
module tb_sr_reg_file;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] op = 2'd0;
    logic [3:0] waddr = 4'd0;
    logic [7:0] wdata = 8'd0;
    logic [3:0] raddr_a = 4'd0;
    logic [3:0] raddr_b = 4'd0;
    logic       clr_all_req = 1'b0;
    logic [7:0] rdata_a, rdata_b;
    logic       busy;

    logic [1:0] d_op = 2'd0;
    logic [3:0] d_waddr = 4'd0;
    logic [7:0] d_wdata = 8'd0;
    logic [3:0] d_ra = 4'd0;
    logic [3:0] d_rb = 4'd0;
    logic       d_req = 1'b0;
    logic [7:0] d_rdata_a, d_rdata_b;
    logic       d_busy;

    int checks = 0;
    int failures = 0;

    logic [7:0] mem [16];
    int         clr_left = 0;

    always #5 clk = ~clk;

    sr_reg_file #(.WIDTH(8), .DEPTH(16)) dut (
        .clk(clk), .rst(rst), .op(op), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .rdata_a(rdata_a), .raddr_b(raddr_b), .rdata_b(rdata_b),
        .clr_all_req(clr_all_req), .busy(busy)
    );

    sr_reg_file #(.WIDTH(8), .DEPTH(12)) dut12 (
        .clk(clk), .rst(rst), .op(d_op), .waddr(d_waddr), .wdata(d_wdata),
        .raddr_a(d_ra), .rdata_a(d_rdata_a), .raddr_b(d_rb), .rdata_b(d_rdata_b),
        .clr_all_req(d_req), .busy(d_busy)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        op = 2'd0;
        clr_all_req = 1'b0;
        d_op = 2'd0;
        d_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = 8'd0;
        clr_left = 0;
        chk("rst_rdata_a", rdata_a, 8'd0);
        chk("rst_rdata_b", rdata_b, 8'd0);
        chk("rst_busy", {7'd0, busy}, 8'd0);
        chk("rst_busy12", {7'd0, d_busy}, 8'd0);
    endtask

    // One clock of traffic on the 16-word instance, checked against the model.
    task automatic step(input logic [1:0] o, input int wa, input logic [7:0] wd,
                        input int ra, input int rb, input logic req);
        logic [7:0] post [16];
        logic [7:0] ea, eb;
        op = o;
        waddr = 4'(wa);
        wdata = wd;
        raddr_a = 4'(ra);
        raddr_b = 4'(rb);
        clr_all_req = req;
        post = mem;
        if (clr_left > 0) begin
            post[16 - clr_left] = 8'd0;
        end else begin
            case (o)
                2'd1: post[wa] = wd;
                2'd2: post[wa] = mem[wa] | wd;
                2'd3: post[wa] = mem[wa] & ~wd;
                default: ;
            endcase
        end
`ifdef SR_REG_FILE_BYPASS_EN
        ea = post[ra];
        eb = post[rb];
`else
        ea = mem[ra];
        eb = mem[rb];
`endif
        if (clr_left > 0) clr_left--;
        else if (req) clr_left = 16;
        @(posedge clk); #1;
        mem = post;
        chk("rdata_a", rdata_a, ea);
        chk("rdata_b", rdata_b, eb);
        chk("busy", {7'd0, busy}, {7'd0, (clr_left > 0)});
    endtask

    initial begin
        int n;
        logic [7:0] e;

        do_reset();

        // Write, then confirm the word and that nothing else changed.
        step(2'd1, 3, 8'hA5, 3, 0, 1'b0);
        step(2'd0, 0, 8'h00, 3, 7, 1'b0);
        chk("w3_read", rdata_a, 8'hA5);
        for (int i = 0; i < 16; i++) step(2'd0, 0, 8'h00, i, 15 - i, 1'b0);

        // Set then clear masks.
        step(2'd2, 3, 8'h0F, 0, 0, 1'b0);
        step(2'd3, 3, 8'h81, 0, 0, 1'b0);
        step(2'd0, 0, 8'h00, 3, 3, 1'b0);
        chk("setclr_a", rdata_a, 8'h2E);
        chk("setclr_b", rdata_b, 8'h2E);

        // Same-cycle read of the word being written.
        do_reset();
        step(2'd1, 5, 8'h3C, 5, 5, 1'b0);
`ifdef SR_REG_FILE_BYPASS_EN
        chk("same_cycle_rd", rdata_a, 8'h3C);
`else
        chk("same_cycle_rd", rdata_a, 8'h00);
`endif

        // Clear-all after filling every word.
        for (int i = 0; i < 16; i++) step(2'd1, i, 8'hFF, i, 0, 1'b0);
        step(2'd0, 0, 8'h00, 0, 0, 1'b1);
        n = busy ? 1 : 0;
        while (busy && n < 40) begin
            step(2'd1, 2, 8'h55, 2, 0, 1'b1);
            if (busy) n++;
        end
        chk("busy_len", 8'(n), 8'd16);
        for (int i = 0; i < 16; i++) begin
            step(2'd0, 0, 8'h00, i, i, 1'b0);
            chk("post_clr", rdata_a, 8'h00);
        end

        // Reset in the middle of a clear-all.
        for (int i = 0; i < 16; i++) step(2'd1, i, 8'h5A, 0, 0, 1'b0);
        step(2'd0, 0, 8'h00, 0, 0, 1'b1);
        for (int i = 0; i < 4; i++) step(2'd0, 0, 8'h00, 0, 0, 1'b0);
        do_reset();
        step(2'd1, 9, 8'h77, 9, 15, 1'b0);
        step(2'd0, 0, 8'h00, 9, 15, 1'b0);
        chk("after_abort_w", rdata_a, 8'h77);
        chk("after_abort_z", rdata_b, 8'h00);

        // Randomized traffic with occasional clear-all requests.
        for (int k = 0; k < 400; k++) begin
            step(2'($urandom_range(0, 3)), int'($urandom_range(0, 15)), 8'($urandom),
                 int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                 ($urandom_range(0, 40) == 0));
        end

        // Non-power-of-two depth: out-of-range write and read.
        for (int i = 0; i < 12; i++) begin
            d_op = 2'd1;
            d_waddr = 4'(i);
            d_wdata = 8'h10 + 8'(i);
            @(posedge clk); #1;
        end
        d_op = 2'd1;
        d_waddr = 4'd13;
        d_wdata = 8'hEE;
        @(posedge clk); #1;
        d_op = 2'd0;
        for (int i = 0; i < 16; i++) begin
            d_ra = 4'(i);
            d_rb = 4'(15 - i);
            @(posedge clk); #1;
            e = (i < 12) ? 8'h10 + 8'(i) : 8'h00;
            chk("d12_rdata_a", d_rdata_a, e);
            e = ((15 - i) < 12) ? 8'h10 + 8'(15 - i) : 8'h00;
            chk("d12_rdata_b", d_rdata_b, e);
        end
        chk("d12_busy", {7'd0, d_busy}, 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sr_reg_file.md
# sr_reg_file

Parametrised register file whose words support set-bits and clear-bits operations, with two registered read ports and a multi-cycle clear-all sequencer. It is the multi-word, multi-bit generalisation of the single-bit set/reset storage cell. It sits beside the CPU's RAM as the flag/state bank for the datapath.

## Interface
Parameters:
- WIDTH, 8, bits per word (>=1)
- DEPTH, 16, number of words (>=2, need not be a power of two)
- ADDR_W, $clog2(DEPTH), address width (derived, not overridden)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- op  in  2  00 HOLD, 01 WRITE, 10 SET, 11 CLR
- waddr  in  ADDR_W  target word for op
- wdata  in  WIDTH  WRITE: new value; SET/CLR: bit mask
- raddr_a  in  ADDR_W  read port A address
- rdata_a  out  WIDTH  read port A data, registered
- raddr_b  in  ADDR_W  read port B address
- rdata_b  out  WIDTH  read port B data, registered
- clr_all_req  in  1  start clear-all sequence (pulse or level; sampled only in IDLE)
- busy  out  1  high while clear-all sequence runs

## Operation
- Word update per op: WRITE → mem[waddr] = wdata; SET → mem[waddr] |= wdata; CLR → mem[waddr] &= ~wdata; HOLD → no change.
- waddr >= DEPTH: op ignored. raddr >= DEPTH: port returns 0.
- FSM states IDLE, CLEARING.
  - IDLE: ops execute. clr_all_req=1 → CLEARING, ptr=0; an op presented in the same cycle still executes.
  - CLEARING: mem[ptr] = 0 each cycle, ptr increments; after ptr = DEPTH-1 is cleared → IDLE. op inputs are dropped, not queued. clr_all_req ignored.
- busy = (state == CLEARING), registered.
- Reads always active, including during CLEARING; both ports may address the same word.
- Reset: every word 0, rdata_a = rdata_b = 0, busy = 0, state IDLE, ptr 0. Reset during CLEARING aborts the sequence (memory is zeroed by reset anyway).

## Timing
- Op applied at edge N is visible in storage after edge N.
- Read latency 1 cycle: rdata at edge N+1 reflects raddr sampled at edge N.
- Same-cycle read of the word being written/set/cleared (or cleared by the sequencer): see Configuration.
- Clear-all occupies exactly DEPTH cycles; busy rises the edge after clr_all_req is sampled and falls DEPTH edges later. The first op accepted is the one in the cycle busy reads 0.

## Configuration
- SR_REG_FILE_BYPASS_EN defined: a read hitting the word updated in the same cycle returns the post-update value (write-first), including 0 for the word cleared by the sequencer.
- Undefined: such a read returns the pre-update value (read-first). No other difference.

## Structure
- Package sr_reg_pkg: op encodings OP_HOLD/OP_WRITE/OP_SET/OP_CLR, FSM state typedef (ST_IDLE, ST_CLEARING), next-word function if the toolflow allows.
- Sub-module sr_word: one WIDTH-bit word with op/mask next-state logic and sequencer-clear input; sr_reg_file instantiates DEPTH of them plus the read muxes and FSM.

## Test plan
- Reset, then WRITE 0xA5 to word 3; read A at 3 next cycle → 0xA5; all other words read 0.
- SET mask 0x0F on word 3, then CLR mask 0x81 → word 3 = 0x2E; port B read at 3 matches port A.
- WRITE 0x3C to word 5 with raddr_a=5 in the same cycle → rdata_a = 0x3C with BYPASS_EN, old value (0) without.
- Fill all DEPTH words with 0xFF, pulse clr_all_req → busy high for exactly 16 cycles; WRITE issued while busy is dropped; afterward all words read 0.
- Assert rst at clear-all cycle 5 → busy 0 next edge, all words 0, new WRITE accepted immediately.
- DEPTH=12: WRITE to waddr 13 → no word changes; read at raddr 14 → 0.
